// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing FETCH..writeback with
// registered control outputs, plus the ALU decoder and the PC-enable term.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t next_state;
  ctrl_t  ctrl_q;

  // Moore output table; anything not set stays zero.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      EXECUTE: next_state = ALUWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_for(FETCH);
    end else begin
      state_q <= next_state;
      ctrl_q  <= ctrl_for(next_state);
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    if (ctrl_q.aluop == 2'b01) begin
      alucontrol = 3'b110;
    end else if (ctrl_q.aluop == 2'b10) begin
      case (funct)
        6'b100010: alucontrol = 3'b110;
        6'b100100: alucontrol = 3'b000;
        6'b100101: alucontrol = 3'b001;
        6'b101010: alucontrol = 3'b111;
        default:   alucontrol = 3'b010;
      endcase
    end
  end

  // Write enables are gated by reset so an aborted instruction never commits.
  assign pcen     = reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
  assign irwrite  = reset & ctrl_q.irwrite;
  assign regwrite = reset & ctrl_q.regwrite;
  assign memwrite = reset & ctrl_q.memwrite;

  assign iord     = ctrl_q.iord;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle MIPS controller: walks each instruction
// class state by state and compares every output against hand-written vectors.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  mips_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .pcsrc      (pcsrc),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, alucontrol, pcsrc}
  logic [18:0] outs;
  assign outs = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, alucontrol, pcsrc};

  localparam logic [18:0] E_RESET  = {4'd0,  8'b0000_0000, 2'b01, 3'b010, 2'b00};
  localparam logic [18:0] E_FETCH  = {4'd0,  8'b1001_0000, 2'b01, 3'b010, 2'b00};
  localparam logic [18:0] E_DECODE = {4'd1,  8'b0000_0000, 2'b11, 3'b010, 2'b00};
  localparam logic [18:0] E_MEMADR = {4'd2,  8'b0000_0001, 2'b10, 3'b010, 2'b00};
  localparam logic [18:0] E_MEMRD  = {4'd3,  8'b0100_0000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_MEMWB  = {4'd4,  8'b0000_0110, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_MEMWR  = {4'd5,  8'b0110_0000, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_ALUWB  = {4'd7,  8'b0000_1010, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_ADDIEX = {4'd9,  8'b0000_0001, 2'b10, 3'b010, 2'b00};
  localparam logic [18:0] E_ADDIWB = {4'd10, 8'b0000_0010, 2'b00, 3'b010, 2'b00};
  localparam logic [18:0] E_JUMP   = {4'd11, 8'b1000_0000, 2'b00, 3'b010, 2'b10};

  task automatic test_reset();
    reset = 1'b0;
    op    = 6'b100011;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== E_RESET) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", outs, E_RESET);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== E_FETCH) begin
      errors++;
      $display("FAIL reset_release_fetch: got %h expected %h", outs, E_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [18:0] exp [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL lw step %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [5] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL sw step %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_rtype(input logic [5:0] f, input logic [2:0] alu_exp);
    logic [18:0] exp [5];
    exp = '{E_FETCH, E_DECODE, {4'd6, 8'b0000_0001, 2'b00, alu_exp, 2'b00}, E_ALUWB, E_FETCH};
    op    = 6'b000000;
    funct = f;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL rtype funct=%b step %0d: got %h expected %h", f, i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [18:0] exp [4];
    exp = '{E_FETCH, E_DECODE, {4'd8, z, 7'b000_0001, 2'b00, 3'b110, 2'b01}, E_FETCH};
    op   = 6'b000100;
    zero = z;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL beq zero=%b step %0d: got %h expected %h", z, i, outs, exp[i]);
      end
      if (i == 2) begin
        // pcen must follow zero within the BRANCH cycle
        zero = ~z;
        #1;
        checks++;
        if (pcen !== ~z) begin
          errors++;
          $display("FAIL beq_pcen_follows_zero: got %b expected %b", pcen, ~z);
        end
        zero = z;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [18:0] exp [5] = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB, E_FETCH};
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL addi step %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_j();
    logic [18:0] exp [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
    op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL j step %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_unknown();
    logic [18:0] exp [3] = '{E_FETCH, E_DECODE, E_FETCH};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL unknown_op step %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [18:0] exp [4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL midreset_sw step %0d: got %h expected %h", i, outs, exp[i]);
      end
    end
    // Assert reset asynchronously inside MEMWR, well before the next rising edge.
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs !== E_RESET) begin
      errors++;
      $display("FAIL midreset_abort: got %h expected %h", outs, E_RESET);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== E_FETCH) begin
      errors++;
      $display("FAIL midreset_release: got %h expected %h", outs, E_FETCH);
    end
  endtask

  initial begin
    reset = 1'b0;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype(6'b101010, 3'b111);
    test_rtype(6'b100100, 3'b000);
    test_rtype(6'b111111, 3'b010);
    test_rtype(6'b100010, 3'b110);
    test_rtype(6'b100101, 3'b001);
    test_rtype(6'b100000, 3'b010);
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi();
    test_j();
    test_unknown();
    test_mid_reset();
    test_addi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Control unit for the multicycle MIPS datapath: a Moore state machine that sequences each instruction over 3–5 clock cycles through a single shared ALU and a unified instruction/data memory. It also contains the ALU decoder. Inputs are the opcode and funct fields from the instruction register and the ALU zero flag. Outputs are all datapath mux selects and write enables, plus the current state for debug.

## Interface
No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset)
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag
- pcen  output  1  PC register enable = pcwrite | (branch & zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register load
- regdst  output  1  write register: 0 = rt, 1 = rd
- memtoreg  output  1  write data: 0 = ALUOut, 1 = Data register
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A: 0 = PC, 1 = A register
- alusrcb  output  2  ALU B: 00 = B register, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- alucontrol  output  3  ALU operation
- pcsrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- state  output  4  current state encoding (debug)

## Operation

**State encoding**
FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are illegal and go to FETCH on the next edge.

**Transitions**
- FETCH→DECODE.
- DECODE by op:
  - lw 100011 or sw 101011 → MEMADR
  - R-type 000000 → EXECUTE
  - beq 000100 → BRANCH
  - addi 001000 → ADDIEX
  - j 000010 → JUMP
  - any other op → FETCH (executed as a NOP, no writes)
- MEMADR → MEMRD if op = lw, otherwise MEMWR.
- MEMRD→MEMWB.
- EXECUTE→ALUWB.
- ADDIEX→ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP → FETCH.

**Outputs by state**
All outputs are Moore outputs. Any signal not listed is 0; alusrcb, pcsrc and aluop default to 00.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01
- DECODE: alusrcb=11
- MEMADR: alusrca=1, alusrcb=10
- MEMRD: iord=1
- MEMWB: memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=1
- EXECUTE: alusrca=1, aluop=10
- ALUWB: regdst=1, regwrite=1
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1
- ADDIEX: alusrca=1, alusrcb=10
- ADDIWB: regwrite=1
- JUMP: pcsrc=10, pcwrite=1

**ALU decoder** (combinational, driven by the internal aluop)
- aluop 00 → 010 (add)
- aluop 01 → 110 (sub)
- aluop 10 → decode funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other funct → 010
- aluop 11 is unused and decodes as 010.

**pcen**
pcen = pcwrite | (branch & zero). zero is sampled combinationally in the BRANCH state only.

## Timing
- The state register updates on the rising edge of clk. Assertion of reset (reset=0) forces state to FETCH immediately, without waiting for a clock edge.
- While reset=0, pcen, irwrite, regwrite and memwrite are forced to 0. The remaining outputs take their FETCH values: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, state=0.
- After reset deasserts, the first rising edge is the first FETCH edge: PC and IR load on it.
- Instruction latencies (cycles from FETCH to the next FETCH):
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - unknown opcode: 2
- All outputs change only after a clock edge. The exceptions are pcen, which also follows zero, and the reset forcing above.
- Reset asserted in any state (including mid-instruction) aborts the instruction. A write enable asserted in the current cycle drops in the same cycle reset asserts, and no register or memory write occurs on the following edge.
- op and funct must be stable from the DECODE cycle until the next FETCH; the IR holds them there.

## Test plan
- Reset: hold reset=0 with op=lw → state=0, pcen=0, irwrite=0, alusrcb=01, alucontrol=010. Release reset → FETCH cycle shows irwrite=1, pcen=1.
- lw (op=100011): state sequence 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0. memwrite stays 0 throughout.
- R-type: op=000000, funct=101010 → EXECUTE shows alucontrol=111, alusrca=1, alusrcb=00. ALUWB shows regdst=1, regwrite=1. Repeat with funct=100100 → 000 and funct=111111 → 010.
- beq: op=000100 with zero=1 in BRANCH → pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 → pcen=0, and the next state is still FETCH.
- sw / addi / j:
  - sw gives sequence 0,1,2,5,0 with memwrite=1 and iord=1 in MEMWR.
  - addi gives 0,1,9,10,0 with regwrite=1 and regdst=0 in ADDIWB.
  - j gives 0,1,11,0 with pcsrc=10 and pcen=1 in JUMP.
  - Unknown op=111111 gives 0,1,0 with no write enables asserted.
- Mid-operation reset: assert reset=0 asynchronously during MEMWR → memwrite drops to 0 before the next edge and state=0. After release, the next instruction fetch proceeds normally.
